keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/keypad_scan_if.sv | 17 +
 rtl/keypad_decode.sv | 38 +++
 rtl/keypad_scan.sv | 163 ++++++++++++++++
 tb/tb_keypad_scan.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: key codes,
// operator codes, scanner FSM states and small helpers.
package calc_pkg;

    localparam logic [3:0] BLANK  = 4'b1111;
    localparam logic [3:0] NEG    = 4'b1011;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    // Clocks after a column change before row_s reflects that column
    // (two synchronizer stages).
    localparam int SETTLE = 2;

    typedef enum logic [2:0] {
        SCAN,
        DEB_PRESS,
        EMIT,
        HOLD,
        DEB_RELEASE
    } state_e;

    typedef enum logic [2:0] {
        SEL_LOAD,
        SEL_OP,
        SEL_CLEAR,
        SEL_BKSP,
        SEL_ENTER
    } sel_e;

    // Index of the lowest-numbered active-low row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Active-low column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key event bus from the keypad scanner to the calculator core.
// Every event is a one-cycle strobe (load, bksp, clear, op_valid, enter)
// with no back-pressure: the consumer must take it in the cycle it is
// high. digit is qualified only by load and op only by op_valid; both
// hold their previous value between strobes.
interface keypad_scan_if;
    logic [3:0] digit;
    logic       load;
    logic       bksp;
    logic       clear;
    logic [1:0] op;
    logic       op_valid;
    logic       enter;

    modport master (output digit, load, bksp, clear, op, op_valid, enter);
    modport slave  (input  digit, load, bksp, clear, op, op_valid, enter);
endinterface

// File: rtl/keypad_decode.sv
// Maps a (row, column) key position to its event type, digit and op code.
module keypad_decode
    import calc_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output sel_e       sel,
    output logic [3:0] digit,
    output logic [1:0] op
);

    // Key map: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
    always_comb begin
        sel   = SEL_LOAD;
        digit = BLANK;
        op    = OP_ADD;
        case ({row_idx, col_idx})
            4'd0:  digit = 4'd1;
            4'd1:  digit = 4'd2;
            4'd2:  digit = 4'd3;
            4'd3:  begin sel = SEL_OP; op = OP_ADD; end
            4'd4:  digit = 4'd4;
            4'd5:  digit = 4'd5;
            4'd6:  digit = 4'd6;
            4'd7:  begin sel = SEL_OP; op = OP_SUB; end
            4'd8:  digit = 4'd7;
            4'd9:  digit = 4'd8;
            4'd10: digit = 4'd9;
            4'd11: sel = SEL_CLEAR;
            4'd12: sel = SEL_BKSP;
            4'd13: digit = 4'd0;
            4'd14: sel = SEL_ENTER;
            4'd15: digit = NEG;
            default: ;
        endcase
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column rotation, press/release debounce, and one
// event strobe per accepted key press.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 250000
)(
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    row,
    output logic [3:0]    col,
    keypad_scan_if.master kp,
    output state_e        dbg_state
);

    localparam int MAXC = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE);

    logic [3:0]    row_meta_q, row_s_q;
    state_e        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    col_q, col_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]    digit_q, digit_d;
    logic [1:0]    op_q, op_d;

    sel_e          dec_sel;
    logic [3:0]    dec_digit;
    logic [1:0]    dec_op;
    logic          row_valid;
    logic          emit;

    keypad_decode u_decode (
        .row_idx (row_idx_q),
        .col_idx (col_idx_q),
        .sel     (dec_sel),
        .digit   (dec_digit),
        .op      (dec_op)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
        end
    end

    // row_s lags the column drive by the synchronizer depth; rows seen in
    // the first SETTLE clocks of a column slot belong to the previous column.
    assign row_valid = (div_cnt_q >= SETTLE_CNT);

    // Next-state logic for scan rotation, debounce and event capture.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        div_cnt_d = div_cnt_q;
        deb_cnt_d = deb_cnt_q;
        digit_d   = digit_q;
        op_d      = op_q;
        unique case (state_q)
            SCAN: begin
                if (row_valid && (row_s_q != 4'hF)) begin
                    state_d   = DEB_PRESS;
                    row_idx_d = lowest_low(row_s_q);
                    deb_cnt_d = '0;
                end else if (div_cnt_q >= SCAN_LAST) begin
                    col_idx_d = col_idx_q + 2'd1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end
            end
            DEB_PRESS: begin
                if (row_s_q[row_idx_q]) begin
                    // Bounce: column never moved, so row_s is already valid
                    // for it and scanning can look again immediately.
                    state_d   = SCAN;
                    deb_cnt_d = '0;
                    div_cnt_d = SETTLE_CNT;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = EMIT;
                    deb_cnt_d = '0;
                    if (dec_sel == SEL_LOAD) digit_d = dec_digit;
                    if (dec_sel == SEL_OP)   op_d    = dec_op;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            EMIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (row_s_q == 4'hF) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                if (row_s_q != 4'hF) begin
                    state_d   = HOLD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = SCAN;
                    deb_cnt_d = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    div_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
        col_d = col_drive(col_idx_d);
    end

    // State, counter and held-value registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            div_cnt_q <= '0;
            deb_cnt_q <= '0;
            digit_q   <= 4'b0000;
            op_q      <= OP_ADD;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            col_q     <= col_d;
            div_cnt_q <= div_cnt_d;
            deb_cnt_q <= deb_cnt_d;
            digit_q   <= digit_d;
            op_q      <= op_q == op_d ? op_q : op_d;
        end
    end

    // Strobes come straight from the EMIT state; reset masks a strobe that
    // would otherwise be visible while reset is asserted.
    assign emit        = (state_q == EMIT) && !reset;
    assign kp.load     = emit && (dec_sel == SEL_LOAD);
    assign kp.op_valid = emit && (dec_sel == SEL_OP);
    assign kp.clear    = emit && (dec_sel == SEL_CLEAR);
    assign kp.bksp     = emit && (dec_sel == SEL_BKSP);
    assign kp.enter    = emit && (dec_sel == SEL_ENTER);
    assign kp.digit    = digit_q;
    assign kp.op       = op_q;
    assign col         = col_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a pin-level keypad model.
module tb_keypad_scan;
    import calc_pkg::*;

    localparam int LAT = 10; // raw capture edge to strobe: 1 sync + DEBOUNCE + 1

    logic        clock;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    state_e      dbg_state;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int pulse_cyc = 0;
    int load_cnt, bksp_cnt, clear_cnt, op_cnt, enter_cnt;
    int col_bad = 0;
    logic [3:0] last_digit;
    logic [1:0] last_op;
    logic row_was_low = 1'b0;

    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .kp        (kp),
        .dbg_state (dbg_state)
    );

    // Clock and keypad matrix: a pressed key pulls its row low while its
    // column is driven low.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Cycle stamp and the edge at which a raw row low is first captured.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (row != 4'hF && !row_was_low) cap_cyc = cyc;
        row_was_low = (row != 4'hF);
    end

    // Strobe monitor.
    always @(negedge clock) begin
        if ($countones(~col) != 1) col_bad++;
        if (kp.load)     begin load_cnt++;  last_digit = kp.digit; pulse_cyc = cyc; end
        if (kp.op_valid) begin op_cnt++;    last_op = kp.op;       pulse_cyc = cyc; end
        if (kp.bksp)     begin bksp_cnt++;  pulse_cyc = cyc; end
        if (kp.clear)    begin clear_cnt++; pulse_cyc = cyc; end
        if (kp.enter)    begin enter_cnt++; pulse_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_counts();
        load_cnt = 0; bksp_cnt = 0; clear_cnt = 0; op_cnt = 0; enter_cnt = 0;
    endtask

    // Wait until the scanner has just switched to column c, then press.
    task automatic press(input int r, input int c);
        logic [3:0] prev;
        logic [3:0] tgt;
        bit found;
        tgt = col_drive(2'(c));
        prev = col;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (col == tgt && prev != tgt) found = 1;
            prev = col;
        end
        check("press_col_wait", 32'(found), 32'd1);
        keys[r*4+c] = 1'b1;
    endtask

    initial begin
        keys = '0;
        reset = 1'b1;
        clear_counts();
        idle(2);
        check("rst_col", 32'(col), 32'hE);
        check("rst_state", 32'(dbg_state), 32'(SCAN));
        check("rst_digit", 32'(kp.digit), 32'h0);
        check("rst_op", 32'(kp.op), 32'h0);
        check("rst_pulses", 32'({kp.load, kp.bksp, kp.clear, kp.op_valid, kp.enter}), 32'h0);
        reset = 1'b0;
        idle(3);

        // Key 5, held 50 clocks.
        clear_counts();
        press(1, 1);
        idle(50);
        keys = '0;
        idle(40);
        check("k5_load_cnt", 32'(load_cnt), 32'd1);
        check("k5_digit", 32'(last_digit), 32'd5);
        check("k5_latency", 32'(pulse_cyc - cap_cyc), 32'(LAT));
        check("k5_other", 32'(bksp_cnt + clear_cnt + op_cnt + enter_cnt), 32'd0);

        // Key D -> minus sign digit.
        clear_counts();
        press(3, 3);
        idle(30);
        keys = '0;
        idle(40);
        check("kd_load_cnt", 32'(load_cnt), 32'd1);
        check("kd_digit", 32'(last_digit), 32'hB);
        check("kd_latency", 32'(pulse_cyc - cap_cyc), 32'(LAT));

        // Key B -> subtract operator.
        clear_counts();
        press(1, 3);
        idle(30);
        keys = '0;
        idle(40);
        check("kb_op_cnt", 32'(op_cnt), 32'd1);
        check("kb_op", 32'(last_op), 32'h1);
        check("kb_other", 32'(load_cnt + bksp_cnt + clear_cnt + enter_cnt), 32'd0);

        // Key 7 bouncing: low 3, high 2, low 20.
        clear_counts();
        press(2, 0);
        idle(3);
        keys = '0;
        idle(2);
        keys[8] = 1'b1;
        idle(20);
        keys = '0;
        idle(40);
        check("k7_load_cnt", 32'(load_cnt), 32'd1);
        check("k7_digit", 32'(last_digit), 32'd7);
        check("k7_latency", 32'(pulse_cyc - cap_cyc), 32'(LAT));

        // Key 1 held, key 4 added in the same column.
        clear_counts();
        press(0, 0);
        idle(20);
        keys[4] = 1'b1;
        idle(20);
        keys = '0;
        idle(40);
        check("k14_load_cnt", 32'(load_cnt), 32'd1);
        check("k14_digit", 32'(last_digit), 32'd1);
        check("k14_latency", 32'(pulse_cyc - cap_cyc), 32'(LAT));

        // Reset during DEB_PRESS of C.
        clear_counts();
        press(2, 3);
        idle(5);
        check("kc_in_deb", 32'(dbg_state), 32'(DEB_PRESS));
        reset = 1'b1;
        keys = '0;
        idle(1);
        check("kc_rst_col", 32'(col), 32'hE);
        check("kc_rst_state", 32'(dbg_state), 32'(SCAN));
        reset = 1'b0;
        idle(30);
        check("kc_clear_cnt", 32'(clear_cnt), 32'd0);

        // Reset while EMIT of * is active.
        clear_counts();
        press(3, 0);
        idle(10);
        @(posedge clock);
        #1;
        reset = 1'b1;
        keys = '0;
        @(negedge clock);
        check("ks_in_emit", 32'(dbg_state), 32'(EMIT));
        check("ks_bksp_masked", 32'(kp.bksp), 32'd0);
        @(negedge clock);
        check("ks_rst_col", 32'(col), 32'hE);
        reset = 1'b0;
        idle(30);
        check("ks_bksp_cnt", 32'(bksp_cnt), 32'd0);

        // Release glitch on #.
        clear_counts();
        press(3, 2);
        idle(30);
        keys = '0;
        idle(5);
        keys[14] = 1'b1;
        idle(20);
        keys = '0;
        idle(40);
        check("kh_enter_cnt", 32'(enter_cnt), 32'd1);
        check("kh_other", 32'(load_cnt + bksp_cnt + clear_cnt + op_cnt), 32'd0);

        // Key 9 already held when reset deasserts.
        clear_counts();
        reset = 1'b1;
        keys[10] = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(60);
        keys = '0;
        idle(40);
        check("k9_load_cnt", 32'(load_cnt), 32'd1);
        check("k9_digit", 32'(last_digit), 32'd9);

        check("col_onehot", 32'(col_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
